// File: rtl/cpu_defs.sv
// Shared CPU address-map definitions: IRQ controller register indices and bus base.
package cpu_defs;

  localparam logic [31:0] IRQ_BASE = 32'hBFC0_1000;

  typedef enum logic [1:0] {
    IRQ_ENABLE = 2'd0,
    IRQ_MODE   = 2'd1,
    IRQ_STATUS = 2'd2,
    IRQ_RAW    = 2'd3
  } irq_reg_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for a vector of asynchronous pins.
module irq_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  // NOTE: asynchronous active-low reset; every flop here is control state, so all are cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/irq_controller.sv
// External interrupt front-end: synchronizes pins, applies edge/level detect and
// masking, and feeds coprocessor-0 Cause IP[7:4]. Word-addressed register port.
module irq_controller
  import cpu_defs::*;
#(
  parameter int N_IRQ       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [N_IRQ-1:0] irq_out
);

  localparam int GUARD_CYCLES = SYNC_STAGES + 1;
  localparam int GW           = $clog2(GUARD_CYCLES + 1);

  logic [N_IRQ-1:0] sync, prev, enable, mode, pending, overrun;
  logic [N_IRQ-1:0] pend_nxt, ovr_nxt, rise, mode_flip, w1c_pend, w1c_ovr;
  logic [GW-1:0]    guard_cnt;
  logic             guard_done, wr_en, wr_enable, wr_mode, wr_status;

  irq_sync #(.WIDTH(N_IRQ), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq_in),
    .q     (sync)
  );

  assign wr_en      = sel & we;
  assign wr_enable  = wr_en && (irq_reg_e'(addr) == IRQ_ENABLE);
  assign wr_mode    = wr_en && (irq_reg_e'(addr) == IRQ_MODE);
  assign wr_status  = wr_en && (irq_reg_e'(addr) == IRQ_STATUS);
  assign mode_flip  = wr_mode ? (wdata[N_IRQ-1:0] ^ mode) : '0;
  assign w1c_pend   = wr_status ? wdata[N_IRQ-1:0] : '0;
  assign w1c_ovr    = wr_status ? wdata[2*N_IRQ-1:N_IRQ] : '0;

  // Edges are suppressed until the synchronizer and prev flop hold real pin data,
  // so a pin held high through reset cannot look like a rising edge.
  assign guard_done = (guard_cnt == GW'(GUARD_CYCLES));
  assign rise       = sync & ~prev & {N_IRQ{guard_done}};

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    pend_nxt = pending;
    ovr_nxt  = overrun;
    for (int i = 0; i < N_IRQ; i++) begin
      if (mode_flip[i]) begin
        pend_nxt[i] = 1'b0;
        ovr_nxt[i]  = 1'b0;
      end else if (!mode[i]) begin
        pend_nxt[i] = sync[i];
        ovr_nxt[i]  = overrun[i] & ~w1c_ovr[i];
      end else begin
        // A rise coinciding with an acknowledge of the same line is a fresh
        // interrupt, not an overrun; a set always beats a clear.
        pend_nxt[i] = rise[i] | (pending[i] & ~w1c_pend[i]);
        ovr_nxt[i]  = (rise[i] & pending[i] & ~w1c_pend[i]) | (overrun[i] & ~w1c_ovr[i]);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev      <= '0;
      enable    <= '0;
      mode      <= '0;
      pending   <= '0;
      overrun   <= '0;
      guard_cnt <= '0;
    end else begin
      prev    <= sync;
      pending <= pend_nxt;
      overrun <= ovr_nxt;
      if (!guard_done) guard_cnt <= guard_cnt + GW'(1);
      if (wr_enable)   enable    <= wdata[N_IRQ-1:0];
      if (wr_mode)     mode      <= wdata[N_IRQ-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (irq_reg_e'(addr))
      IRQ_ENABLE: rdata[N_IRQ-1:0]   = enable;
      IRQ_MODE:   rdata[N_IRQ-1:0]   = mode;
      IRQ_STATUS: rdata[2*N_IRQ-1:0] = {overrun, pending};
      IRQ_RAW:    rdata[N_IRQ-1:0]   = sync;
      default:    rdata              = '0;
    endcase
  end

  assign irq_out = pending & enable;

endmodule
